// File: rtl/alu_pipe_n.sv
// Two-stage valid/ready Y86 ALU (ADD/SUB/AND/XOR) with per-result ZF/SF/OF and illegal-op flag.
// Optional ALU_CC_REG_EN adds an in_set_cc input and a committed condition-code register cc_q.
module alu_pipe_n #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef ALU_CC_REG_EN
   input  logic             in_set_cc,
   output logic [2:0]       cc_q,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_zf,
   output logic             out_sf,
   output logic             out_of,
   output logic             out_err
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;

   logic             s1_valid_q;
   logic [3:0]       s1_op_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   logic             s2_valid_q;
   logic [WIDTH-1:0] res_q;
   logic             zf_q, sf_q, of_q, err_q;
`ifdef ALU_CC_REG_EN
   logic             s1_set_cc_q, s2_set_cc_q;
`endif

   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] res_d;
   logic             zf_d, sf_d, of_d, err_d;

   // No skid buffer: a stalled output backs up straight to in_ready.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      res_d = '0;
      of_d  = 1'b0;
      err_d = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            res_d = s1_b_q + s1_a_q;
            of_d  = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OP_SUB: begin
            // subq computes rB - rA
            res_d = s1_b_q - s1_a_q;
            of_d  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (res_d[WIDTH-1] != s1_b_q[WIDTH-1]);
         end
         OP_AND:  res_d = s1_a_q & s1_b_q;
         OP_XOR:  res_d = s1_a_q ^ s1_b_q;
         default: err_d = 1'b1;
      endcase
      zf_d = !err_d && (res_d == '0);
      sf_d = res_d[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         zf_q       <= 1'b0;
         sf_q       <= 1'b0;
         of_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_op_q <= in_op;
               s1_a_q  <= in_a;
               s1_b_q  <= in_b;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               res_q <= res_d;
               zf_q  <= zf_d;
               sf_q  <= sf_d;
               of_q  <= of_d;
               err_q <= err_d;
            end
         end
      end
   end

`ifdef ALU_CC_REG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_set_cc_q <= 1'b0;
         s2_set_cc_q <= 1'b0;
         cc_q        <= 3'b000;
      end else begin
         if (s1_adv && in_valid) s1_set_cc_q <= in_set_cc;
         if (s2_adv && s1_valid_q) s2_set_cc_q <= s1_set_cc_q;
         // Commit only when the consumer actually takes a legal result.
         if (s2_valid_q && out_ready && !err_q && s2_set_cc_q)
            cc_q <= {zf_q, sf_q, of_q};
      end
   end
`endif

   assign out_valid = s2_valid_q;
   assign out_res   = res_q;
   assign out_zf    = zf_q;
   assign out_sf    = sf_q;
   assign out_of    = of_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_alu_pipe_n.sv
// Bench for alu_pipe_n: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_alu_pipe_n;
   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zf, sf, of, err;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   in_op;
   logic [W-1:0] in_a, in_b, out_res;
   logic         out_zf, out_sf, out_of, out_err;

   logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [3:0]   n_in_op;
   logic [7:0]   n_a, n_b, n_res;
   logic         n_zf, n_sf, n_of, n_err;
`ifdef ALU_CC_REG_EN
   logic         in_set_cc, n_set_cc;
   logic [2:0]   cc_q, n_cc;
`endif

   int n_vec = 0;
   int n_bad = 0;
   res_t exp_q[$];
   res_t obs_q[$];

   alu_pipe_n #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b),
`ifdef ALU_CC_REG_EN
      .in_set_cc(in_set_cc), .cc_q(cc_q),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .out_err(out_err));

   alu_pipe_n #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op),
      .in_a(n_a), .in_b(n_b),
`ifdef ALU_CC_REG_EN
      .in_set_cc(n_set_cc), .cc_q(n_cc),
`endif
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_res(n_res),
      .out_zf(n_zf), .out_sf(n_sf), .out_of(n_of), .out_err(n_err));

   // Reference: signed results computed one bit wider; overflow = doesn't fit in W bits.
   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      logic signed [W:0] wide;
      r = '0;
      wide = '0;
      case (op)
         4'd0: begin
            wide  = $signed({a[W-1], a}) + $signed({b[W-1], b});
            r.res = wide[W-1:0];
            r.of  = wide[W] ^ wide[W-1];
         end
         4'd1: begin
            wide  = $signed({b[W-1], b}) - $signed({a[W-1], a});
            r.res = wide[W-1:0];
            r.of  = wide[W] ^ wide[W-1];
         end
         4'd2: r.res = a & b;
         4'd3: r.res = a ^ b;
         default: r.err = 1'b1;
      endcase
      r.zf = !r.err && (r.res == '0);
      r.sf = r.res[W-1];
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b));
         if (out_valid && out_ready) obs_q.push_back(res_t'({out_res, out_zf, out_sf, out_of, out_err}));
      end
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic flush;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; in_op = 4'd0; in_a = 64'h1234; in_b = 64'h5678; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_res !== '0) begin
         n_bad++; $display("FAIL reset_out: valid=%b res=%h want 0/0", out_valid, out_res);
      end
      n_vec++;
      if ({out_zf, out_sf, out_of, out_err} !== 4'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000", {out_zf, out_sf, out_of, out_err});
      end
`ifdef ALU_CC_REG_EN
      n_vec++;
      if (cc_q !== 3'b000) begin n_bad++; $display("FAIL reset_cc: got %b want 000", cc_q); end
`endif
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || obs_q.size() != 0) begin
         n_bad++; $display("FAIL reset_no_output: valid=%b outputs=%0d want 0/0", out_valid, obs_q.size());
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_flags;
      logic [W-1:0] a;
      a = 64'h0000_0055_5555_52AA;
      in_valid = 1'b1; in_op = 4'd2; in_a = a; in_b = 64'hFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flags_latency1: valid=%b want 0", out_valid); end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_res !== 64'h2AA || out_zf !== 1'b0 || out_err !== 1'b0) begin
         n_bad++; $display("FAIL flags_and: valid=%b res=%h zf=%b want 1/2aa/0", out_valid, out_res, out_zf);
      end
      issue(4'd2, a, 64'h0);
      n_vec++;
      if (out_valid !== 1'b1 || out_res !== 64'h0 || out_zf !== 1'b1 || out_sf !== 1'b0) begin
         n_bad++; $display("FAIL flags_zero: valid=%b res=%h zf=%b want 1/0/1", out_valid, out_res, out_zf);
      end
      flush();
   endtask

   task automatic test_overflow;
      issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
      n_vec++;
      if (out_res !== 64'hFFFF_FFFF_FFFF_FFFE || out_sf !== 1'b1 || out_of !== 1'b1 || out_zf !== 1'b0) begin
         n_bad++; $display("FAIL ovf_add: res=%h sf=%b of=%b want fffffffffffffffe/1/1", out_res, out_sf, out_of);
      end
      issue(4'd1, 64'h1, 64'h8000_0000_0000_0000);
      n_vec++;
      if (out_res !== 64'h7FFF_FFFF_FFFF_FFFF || out_of !== 1'b1 || out_sf !== 1'b0) begin
         n_bad++; $display("FAIL ovf_sub: res=%h sf=%b of=%b want 7fffffffffffffff/0/1", out_res, out_sf, out_of);
      end
      issue(4'd1, 64'h5, 64'h3);
      n_vec++;
      if (out_res !== 64'hFFFF_FFFF_FFFF_FFFE || out_of !== 1'b0 || out_sf !== 1'b1) begin
         n_bad++; $display("FAIL sub_order: res=%h of=%b want fffffffffffffffe/0", out_res, out_of);
      end
      flush();
   endtask

   task automatic test_backpressure;
      logic [3:0]   ops[4];
      logic [W-1:0] as[4], bs[4];
      logic [W-1:0] hold;
      int idx, cyc;
      logic acc;
      for (int i = 0; i < 4; i++) begin
         ops[i] = 4'($urandom_range(0, 3)); as[i] = {$urandom, $urandom}; bs[i] = {$urandom, $urandom};
      end
      out_ready = 1'b0; idx = 0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx];
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      n_vec++;
      if (idx != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
      in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx];
      hold = out_res;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== hold) begin
            n_bad++; $display("FAIL bp_stall: in_ready=%b valid=%b res=%h want 0/1/%h", in_ready, out_valid, out_res, hold);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1; cyc = 0;
      while (idx < 4 && cyc < 20) begin
         in_valid = 1'b1; in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx];
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0; cyc = 0;
      while (obs_q.size() < 4 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (obs_q.size() != 4 || exp_q.size() != 4) begin
         n_bad++; $display("FAIL bp_count: got %0d results want 4", obs_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (i >= obs_q.size() || obs_q[i] !== model(ops[i], as[i], bs[i])) begin
            n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", i,
                              (i < obs_q.size()) ? obs_q[i] : res_t'('x), model(ops[i], as[i], bs[i]));
         end
      end
      flush();
   endtask

   task automatic test_illegal;
`ifdef ALU_CC_REG_EN
      in_set_cc = 1'b1;
      issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
      flush();
      n_vec++;
      if (cc_q !== 3'b011) begin n_bad++; $display("FAIL cc_set: got %b want 011", cc_q); end
`endif
      issue(4'd7, 64'h0, 64'h0);
      n_vec++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_res !== '0) begin
         n_bad++; $display("FAIL illegal_err: valid=%b err=%b res=%h want 1/1/0", out_valid, out_err, out_res);
      end
      n_vec++;
      if ({out_zf, out_sf, out_of} !== 3'b000) begin
         n_bad++; $display("FAIL illegal_flags: got %b want 000", {out_zf, out_sf, out_of});
      end
      flush();
`ifdef ALU_CC_REG_EN
      n_vec++;
      if (cc_q !== 3'b011) begin n_bad++; $display("FAIL cc_illegal: got %b want 011", cc_q); end
      in_set_cc = 1'b0;
`endif
   endtask

   task automatic test_width8;
      n_in_valid = 1'b1; n_in_op = 4'd0; n_a = 8'h01; n_b = 8'h7F;
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      n_vec++;
      if (n_out_valid !== 1'b0) begin n_bad++; $display("FAIL w8_latency: valid=%b want 0", n_out_valid); end
      @(posedge clk); #1;
      n_vec++;
      if (n_out_valid !== 1'b1 || n_res !== 8'h80 || n_sf !== 1'b1 || n_of !== 1'b1 || n_zf !== 1'b0) begin
         n_bad++; $display("FAIL w8_add: res=%h sf=%b of=%b want 80/1/1", n_res, n_sf, n_of);
      end
      n_in_valid = 1'b1; n_in_op = 4'd3; n_a = 8'hAA; n_b = 8'hAA;
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (n_out_valid !== 1'b1 || n_res !== 8'h00 || n_zf !== 1'b1 || n_of !== 1'b0) begin
         n_bad++; $display("FAIL w8_xor: res=%h zf=%b want 00/1", n_res, n_zf);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      int cyc;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         in_a      = ($urandom_range(0, 5) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
         in_b      = ($urandom_range(0, 5) == 0) ? in_a : {$urandom, $urandom};
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
      while (obs_q.size() < exp_q.size() && cyc < 20) begin @(posedge clk); #1; cyc++; end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL rand_count: got %0d results want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL rand[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      n_in_valid = 1'b0; n_in_op = 4'd0; n_a = '0; n_b = '0; n_out_ready = 1'b1;
`ifdef ALU_CC_REG_EN
      in_set_cc = 1'b0; n_set_cc = 1'b0;
`endif
      test_reset();
      test_flags();
      test_overflow();
      test_backpressure();
      test_illegal();
      test_width8();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
